e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving busy cycles for div/divu.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MDU_a  input  32  operand rs (dividend/multiplicand/mthi/mtlo source).
REQ-006 MDU_b  input  32  operand rt (divisor/multiplier).
REQ-007 CU_MDU_op  input  4  operation select from controller.
REQ-008 MDU_start  input  1  one-cycle request to begin mult/multu/div/divu.
REQ-009 E_MDU_busy  output  1  stall request to hazard unit.
REQ-010 E_MDU_out  output  32  HI for mfhi, LO for mflo, else 0.

Function
REQ-011 Ops SHALL be: mduNone, mduMult, mduMultu, mduDiv, mduDivu, mduMfhi, mduMflo, mduMthi, mduMtlo.
REQ-012 States SHALL be IDLE and RUN; IDLE->RUN on edge with MDU_start=1, op in {mult,multu,div,divu}, state IDLE.
REQ-013 On that edge the down-counter SHALL load MULT_CYCLES or DIV_CYCLES and pending HI/LO SHALL latch the full result.
REQ-014 mult/multu SHALL form the 64-bit signed/unsigned product, HI=[63:32], LO=[31:0].
REQ-015 div/divu SHALL give LO=quotient, HI=remainder, signed ops truncating toward zero, remainder sign = dividend sign.
REQ-016 In RUN the counter SHALL decrement each edge; on the edge it goes 1->0, pending values SHALL commit to HI/LO and state SHALL return to IDLE.
REQ-017 E_MDU_busy SHALL equal MDU_start OR (state==RUN), combinationally, so the requesting cycle also stalls.
REQ-018 After a start edge, busy SHALL stay high exactly N cycles (N=MULT_CYCLES/DIV_CYCLES); new HI/LO SHALL be readable the first cycle busy is low.
REQ-019 MDU_start SHALL be ignored while state is RUN.
REQ-020 mthi/mtlo SHALL write MDU_a into HI/LO on the edge only when state is IDLE and MDU_start=0; otherwise ignored.
REQ-021 E_MDU_out SHALL be combinational from committed HI/LO; mfhi/mflo during RUN SHALL return pre-operation values (hazard unit stalls them).
REQ-022 Signed div of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give LO=32'h8000_0000, HI=0.

Reset
REQ-023 Asserting reset, including mid-RUN, SHALL immediately force HI=0, LO=0, pending=0, counter=0, state=IDLE, and abandon any operation.
REQ-024 During and after reset with MDU_start=0, E_MDU_busy SHALL be 0 and E_MDU_out SHALL be 0.

Configuration
REQ-025 Macro MDU_DIVZERO_HOLD_EN SHALL control divide-by-zero handling.
REQ-026 With MDU_DIVZERO_HOLD_EN defined, div/divu with MDU_b=0 SHALL still busy DIV_CYCLES but leave HI/LO unchanged at commit.
REQ-027 Without it, div/divu with MDU_b=0 SHALL commit HI=MDU_a, LO=32'hFFFF_FFFF.

Structure
REQ-028 CU_MDU_op encodings (4'b0000 mduNone upward) SHALL live in the shared constants package beside the ALU op codes.
REQ-029 MULT_CYCLES/DIV_CYCLES defaults SHALL be shared package constants.
REQ-030 No sub-module SHALL be used; FSM, counter and arithmetic are inline.

Verification
REQ-031 mult a=32'hFFFF_FFFF b=2 start -> busy 5 cycles (plus start cycle), then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE.
REQ-032 multu same operands -> HI=32'h0000_0001, LO=32'hFFFF_FFFE.
REQ-033 div a=-7 b=2 -> busy 10 cycles, LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; divu a=7 b=2 -> LO=3, HI=1.
REQ-034 mthi 32'h1234_5678 then mfhi -> E_MDU_out=32'h1234_5678; mtlo during RUN -> LO unchanged.
REQ-035 reset asserted 3 cycles into div -> busy=0, HI=LO=0 same cycle; no commit afterward.
REQ-036 div a=5 b=0 -> with macro HI/LO unchanged; without macro HI=5, LO=32'hFFFF_FFFF.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared execute-stage constants: ALU/MDU operation encodings, MDU latency
// defaults and the signed-divide helper used by the multiply/divide unit.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        aluAdd = 4'b0000,
        aluSub = 4'b0001,
        aluAnd = 4'b0010,
        aluOr  = 4'b0011,
        aluXor = 4'b0100,
        aluNor = 4'b0101,
        aluSlt = 4'b0110,
        aluSltu = 4'b0111,
        aluLui = 4'b1000
    } alu_op_e;

    typedef enum logic [3:0] {
        mduNone  = 4'b0000,
        mduMult  = 4'b0001,
        mduMultu = 4'b0010,
        mduDiv   = 4'b0011,
        mduDivu  = 4'b0100,
        mduMfhi  = 4'b0101,
        mduMflo  = 4'b0110,
        mduMthi  = 4'b0111,
        mduMtlo  = 4'b1000
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // Signed divide on magnitudes so INT_MIN / -1 wraps to INT_MIN with
    // remainder 0; returns {remainder, quotient}. Caller guards b == 0.
    function automatic logic [63:0] mdu_sdiv(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        quo   = mag_a / mag_b;
        rem   = mag_a % mag_b;
        if (a[31] ^ b[31]) begin
            quo = 32'd0 - quo;
        end else begin
            quo = quo;
        end
        if (a[31]) begin
            rem = 32'd0 - rem;
        end else begin
            rem = rem;
        end
        return {rem, quo};
    endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// Optional macro MDU_DIVZERO_HOLD_EN: divide by zero leaves HI/LO unchanged.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MDU_a,
    input  logic [31:0] MDU_b,
    input  logic [3:0]  CU_MDU_op,
    input  logic        MDU_start,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      phi_q, phi_d;
    logic [31:0]      plo_q, plo_d;
    logic [63:0]      res_s;
    logic             is_mult_s;
    logic             is_div_s;

    // Full 64-bit result of the requested operation, {HI, LO}.
    always_comb begin
        res_s     = 64'd0;
        is_mult_s = 1'b0;
        is_div_s  = 1'b0;
        case (CU_MDU_op)
            mduMult: begin
                is_mult_s = 1'b1;
                res_s = {{32{MDU_a[31]}}, MDU_a} * {{32{MDU_b[31]}}, MDU_b};
            end
            mduMultu: begin
                is_mult_s = 1'b1;
                res_s = {32'd0, MDU_a} * {32'd0, MDU_b};
            end
            mduDiv, mduDivu: begin
                is_div_s = 1'b1;
                if (MDU_b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
                    res_s = {hi_q, lo_q};
`else
                    res_s = {MDU_a, 32'hFFFF_FFFF};
`endif
                end else if (CU_MDU_op == mduDiv) begin
                    res_s = mdu_sdiv(MDU_a, MDU_b);
                end else begin
                    res_s = {MDU_a % MDU_b, MDU_a / MDU_b};
                end
            end
            default: begin
                res_s = 64'd0;
            end
        endcase
    end

    // Next-state: start/latch in IDLE, count down and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            S_IDLE: begin
                if (MDU_start && (is_mult_s || is_div_s)) begin
                    state_d = S_RUN;
                    cnt_d   = is_mult_s ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    phi_d   = res_s[63:32];
                    plo_d   = res_s[31:0];
                end else if (!MDU_start && (CU_MDU_op == mduMthi)) begin
                    hi_d = MDU_a;
                end else if (!MDU_start && (CU_MDU_op == mduMtlo)) begin
                    lo_d = MDU_a;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_IDLE;
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, committed and pending HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    // The requesting cycle stalls too, hence MDU_start in the busy term.
    always_comb begin
        E_MDU_busy = MDU_start | (state_q == S_RUN);
        case (CU_MDU_op)
            mduMfhi: E_MDU_out = hi_q;
            mduMflo: E_MDU_out = lo_q;
            default: E_MDU_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: per-cycle expected busy/out from a plain
// arithmetic model, checked by an independent monitor on the falling edge.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] MDU_a = 32'd0;
    logic [31:0] MDU_b = 32'd0;
    logic [3:0]  CU_MDU_op = 4'd0;
    logic        MDU_start = 1'b0;
    logic        E_MDU_busy;
    logic [31:0] E_MDU_out;

    e_mdu dut (
        .clk(clk), .reset(reset), .MDU_a(MDU_a), .MDU_b(MDU_b),
        .CU_MDU_op(CU_MDU_op), .MDU_start(MDU_start),
        .E_MDU_busy(E_MDU_busy), .E_MDU_out(E_MDU_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic [31:0] out;
        logic [3:0]  op;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // Reference state: architectural HI/LO plus remaining busy cycles.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    int          m_left = 0;

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        if ((op == mduDiv || op == mduDivu) && b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
            return {m_hi, m_lo};
`else
            return {a, 32'hFFFF_FFFF};
`endif
        end
        case (op)
            mduMult: begin p = 64'(sa * sb_); return p; end
            mduMultu: begin p = {32'd0, a} * {32'd0, b}; return p; end
            mduDiv: begin
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    task automatic cyc(input logic r, input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] res;
        @(posedge clk);
        #1;
        reset = r; MDU_start = st; CU_MDU_op = op; MDU_a = a; MDU_b = b;
        if (r) begin
            m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_left = 0;
        end
        e.busy = st | (m_left > 0);
        e.out  = (op == mduMfhi) ? m_hi : (op == mduMflo) ? m_lo : 32'd0;
        e.op   = op;
        sb.push_back(e);
        if (!r) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (st && (op == mduMult || op == mduMultu || op == mduDiv || op == mduDivu)) begin
                res    = ref_result(op, a, b);
                m_phi  = res[63:32];
                m_plo  = res[31:0];
                m_left = (op == mduMult || op == mduMultu) ? MDU_MULT_CYCLES : MDU_DIV_CYCLES;
            end else if (!st && op == mduMthi) begin
                m_hi = a;
            end else if (!st && op == mduMtlo) begin
                m_lo = a;
            end
        end
    endtask

    task automatic idle_read(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, (i % 2 == 0) ? mduMfhi : mduMflo, 32'd0, 32'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        cyc(1'b0, 1'b1, op, a, b);
        idle_read(12);
    endtask

    // Monitor: compare each presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                cyc_no++;
                if (E_MDU_busy !== e.busy) begin
                    n_bad++;
                    $display("FAIL busy vec=%0d op=%0d got=%b want=%b", cyc_no, e.op, E_MDU_busy, e.busy);
                end
                if (E_MDU_out !== e.out) begin
                    n_bad++;
                    $display("FAIL out vec=%0d op=%0d got=%h want=%h", cyc_no, e.op, E_MDU_out, e.out);
                end
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, mduMfhi, 32'd0, 32'd0);
        idle_read(2);
        run_op(mduMult,  32'hFFFF_FFFF, 32'd2);
        run_op(mduMultu, 32'hFFFF_FFFF, 32'd2);
        run_op(mduDiv,   32'hFFFF_FFF9, 32'd2);
        run_op(mduDivu,  32'd7, 32'd2);
        run_op(mduDiv,   32'h8000_0000, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b0, mduMthi, 32'h1234_5678, 32'd0);
        idle_read(2);
        cyc(1'b0, 1'b1, mduMult, 32'd3, 32'd4);
        cyc(1'b0, 1'b0, mduMtlo, 32'hDEAD_BEEF, 32'd0);
        cyc(1'b0, 1'b1, mduDiv, 32'd9, 32'd2);
        idle_read(6);
        cyc(1'b0, 1'b1, mduDiv, 32'd100, 32'd7);
        idle_read(3);
        cyc(1'b1, 1'b0, mduMfhi, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, mduMflo, 32'd0, 32'd0);
        idle_read(12);
        run_op(mduDiv,  32'd5, 32'd0);
        run_op(mduDivu, 32'd5, 32'd0);
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 8));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), op, a, b);
        end
        cyc(1'b0, 1'b0, mduMfhi, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
